reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
- Debug-side reader for the CPU register file: on command, walks registers 0..NUM_REGS-1 through a dedicated read port and serializes each word as bytes to the debug UART transmitter.
- Uses a valid/ready byte handshake.
- Sits between the register file's read port (muxed in while the CPU is halted) and the UART TX of the debug unit.

Parameters:
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1).
- ADDR_WIDTH, 5, register address width; NUM_REGS <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width; must be a multiple of 8; BYTES = DATA_WIDTH/8.

Ports:
- clk  input  1  system clock, rising-edge active.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle dump request; honoured only in IDLE.
- o_rd_addr  output  ADDR_WIDTH  register file read address.
- i_rd_data  input  DATA_WIDTH  register file read data. Valid by the second rising edge after o_rd_addr changes.
- o_tx_data  output  8  byte to UART TX.
- o_tx_valid  output  1  o_tx_data valid.
- i_tx_ready  input  1  UART TX accepts the byte this cycle.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async assert, sync-to-clk deassert): state IDLE, o_rd_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, byte index=0. Reset mid-dump aborts immediately; o_tx_valid drops asynchronously; no resume.
- States: IDLE, ADDR, LOAD, SEND, DONE.
- IDLE: i_start=1 -> ADDR with o_rd_addr=0. i_start in any other state is ignored (no queuing).
- ADDR: o_rd_addr is stable for one cycle -> LOAD.
- LOAD: at the closing rising edge, capture i_rd_data into the shift register, set byte index=0 and o_tx_valid=1 -> SEND. o_rd_addr must not change during ADDR or LOAD.
- SEND: o_tx_data = captured word bits, MSB byte first. A byte is transferred on a rising edge where o_tx_valid=1 and i_tx_ready=1.
  - o_tx_valid and o_tx_data stay stable until that transfer; valid never drops while a byte is pending.
  - On transfer of a non-last byte, the index increments and the next byte is presented in the following cycle (no bubble).
  - On transfer of the last byte, o_tx_valid drops.
    - If o_rd_addr < NUM_REGS-1: o_rd_addr increments -> ADDR.
    - Else -> DONE.
- i_tx_ready while o_tx_valid=0 is ignored.
- DONE: o_done=1 for exactly one cycle, o_busy=1 -> IDLE (o_rd_addr returns to 0, o_busy=0).
- Throughput with i_tx_ready held high: BYTES+2 cycles per register. Default config: 6 cycles/register, 192 cycles from the cycle after i_start to DONE.
- o_rd_addr wrap: never exceeds NUM_REGS-1; no modulo roll-over inside a dump.
- Stall: i_tx_ready low for N cycles extends SEND by N cycles; no other state is affected.

Optional Feature:
- Macro REG_DUMP_CHECKSUM_EN.
- When defined: after the last data byte, an extra SEND phase emits one checksum byte = XOR of all DATA bytes sent in this dump. It uses the same handshake and precedes DONE; the accumulator clears on i_start acceptance and on reset. Default dump: 129 bytes, 193 cycles with ready high.
- When undefined: no checksum logic; exactly NUM_REGS*BYTES bytes, then DONE.

Test Plan:
- Register model returns 32'h0000_0000 + (addr*32'h0101_0101); pulse i_start, i_tx_ready=1 -> 128 bytes; register 1 gives 01,01,01,01 and register 31 gives 1F,1F,1F,1F; o_done high exactly once, 192 cycles after start; o_busy low afterwards.
- Reg 5 = 32'hDEAD_BEEF, i_tx_ready toggling 1-of-3 cycles -> bytes DE,AD,BE,EF for reg 5; o_tx_data/o_tx_valid stable throughout every stall; no duplicated or dropped byte.
- i_start re-pulsed at cycles 10 and 100 of a dump -> ignored; byte count stays 128; single o_done.
- i_rst_n low for 1 cycle mid-SEND on reg 7 -> o_tx_valid=0 immediately, o_busy=0, o_rd_addr=0; a following i_start restarts from register 0.
- i_tx_ready=0 for entire dump -> first byte held valid indefinitely, o_rd_addr stays 0, no o_done.
- REG_DUMP_CHECKSUM_EN defined, all registers 32'hA5A5_A5A5 except reg 0 = 0 -> 129th byte = 8'h00 (124 bytes of A5 XOR to 0); with reg 1 = 32'h0000_00FF instead -> 129th byte = 8'hFF.

Source files
------------

// File: rtl/reg_dump_reader.sv
// ============================================================================
// Module   : reg_dump_reader
// Purpose  : Debug-side register file dumper. On i_start it reads registers
//            0..NUM_REGS-1 through a dedicated read port and streams every
//            word, most-significant byte first, to the debug UART transmitter
//            over a valid/ready byte handshake.
// Options  : REG_DUMP_CHECKSUM_EN - when defined, one extra byte holding the
//            XOR of every data byte in the dump is sent before DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module reg_dump_reader #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int BYTES = DATA_WIDTH / 8;
    // Byte index needs at least one bit even for single-byte registers.
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [IDX_W-1:0]      c_last_idx  = IDX_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_REGS - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state and next-state values
    // ------------------------------------------------------------------------
    state_t                  r_state_q;
    state_t                  r_state_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic [ADDR_WIDTH-1:0]   r_addr_d;
    logic [DATA_WIDTH-1:0]   r_shift_q;
    logic [DATA_WIDTH-1:0]   r_shift_d;
    logic [IDX_W-1:0]        r_idx_q;
    logic [IDX_W-1:0]        r_idx_d;
    logic                    r_tx_valid_q;
    logic                    r_tx_valid_d;

`ifdef REG_DUMP_CHECKSUM_EN
    // Running XOR of data bytes and a flag marking the trailing checksum byte.
    logic [7:0]              r_csum_q;
    logic [7:0]              r_csum_d;
    logic                    r_csum_phase_q;
    logic                    r_csum_phase_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [7:0] w_tx_byte;
    logic       w_xfer;

    // The byte on the wire is always the top byte of the shift register.
    assign w_tx_byte = r_shift_q[DATA_WIDTH-1 -: 8];
    assign w_xfer    = r_tx_valid_q & i_tx_ready;

    // ------------------------------------------------------------------------
    // Next-state logic: walk ADDR -> LOAD -> SEND per register, then DONE
    // ------------------------------------------------------------------------
    always_comb begin
        r_state_d    = r_state_q;
        r_addr_d     = r_addr_q;
        r_shift_d    = r_shift_q;
        r_idx_d      = r_idx_q;
        r_tx_valid_d = r_tx_valid_q;
`ifdef REG_DUMP_CHECKSUM_EN
        r_csum_d       = r_csum_q;
        r_csum_phase_d = r_csum_phase_q;
`endif

        case (r_state_q)
            S_IDLE: begin
                // Start is only accepted here; elsewhere it is dropped.
                if (i_start) begin
                    r_state_d = S_ADDR;
                    r_addr_d  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    r_csum_d       = 8'h00;
                    r_csum_phase_d = 1'b0;
`endif
                end
            end

            S_ADDR: begin
                // Address has been presented for one cycle; read data
                // settles by the end of LOAD.
                r_state_d = S_LOAD;
            end

            S_LOAD: begin
                r_shift_d    = i_rd_data;
                r_idx_d      = '0;
                r_tx_valid_d = 1'b1;
                r_state_d    = S_SEND;
            end

            S_SEND: begin
                if (w_xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    if (r_csum_phase_q) begin
                        // Checksum byte accepted: dump is finished.
                        r_csum_phase_d = 1'b0;
                        r_tx_valid_d   = 1'b0;
                        r_shift_d      = '0;
                        r_state_d      = S_DONE;
                    end else begin
                        r_csum_d = r_csum_q ^ w_tx_byte;
`endif
                        r_shift_d = r_shift_q << 8;
                        if (r_idx_q != c_last_idx) begin
                            // Next byte shows up the following cycle.
                            r_idx_d = r_idx_q + 1'b1;
                        end else if (r_addr_q < c_last_addr) begin
                            r_tx_valid_d = 1'b0;
                            r_addr_d     = r_addr_q + 1'b1;
                            r_state_d    = S_ADDR;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Keep valid high and present the checksum
                            // including the byte being accepted now.
                            r_csum_phase_d = 1'b1;
                            r_shift_d      = DATA_WIDTH'(r_csum_q ^ w_tx_byte)
                                             << (DATA_WIDTH - 8);
`else
                            r_tx_valid_d = 1'b0;
                            r_state_d    = S_DONE;
`endif
                        end
`ifdef REG_DUMP_CHECKSUM_EN
                    end
`endif
                end
            end

            S_DONE: begin
                r_addr_d  = '0;
                r_state_d = S_IDLE;
            end

            default: begin
                r_state_d    = S_IDLE;
                r_addr_d     = '0;
                r_tx_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers with asynchronous abort on reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q    <= S_IDLE;
            r_addr_q     <= '0;
            r_shift_q    <= '0;
            r_idx_q      <= '0;
            r_tx_valid_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum_q       <= 8'h00;
            r_csum_phase_q <= 1'b0;
`endif
        end else begin
            r_state_q    <= r_state_d;
            r_addr_q     <= r_addr_d;
            r_shift_q    <= r_shift_d;
            r_idx_q      <= r_idx_d;
            r_tx_valid_q <= r_tx_valid_d;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum_q       <= r_csum_d;
            r_csum_phase_q <= r_csum_phase_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_rd_addr  = r_addr_q;
    assign o_tx_data  = w_tx_byte;
    assign o_tx_valid = r_tx_valid_q;
    assign o_busy     = (r_state_q != S_IDLE);
    assign o_done     = (r_state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// ============================================================================
// Module   : tb_reg_dump_reader
// Purpose  : Directed self-checking bench for reg_dump_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int c_nbytes   = 129;
    localparam int c_done_cyc = 193;
`else
    localparam int c_nbytes   = 128;
    localparam int c_done_cyc = 192;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [4:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] regs [32];
    logic [7:0]  byte_q [$];
    int          done_cnt = 0;
    logic        pend = 1'b0;
    logic [7:0]  pend_data = 8'h00;

    reg_dump_reader #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    // Register file with one cycle of read latency
    always @(posedge clk) i_rd_data <= regs[o_rd_addr];

    // Byte collector, done counter and stall-stability monitor
    always @(negedge clk) begin
        if (!i_rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                n_checks++;
                if (o_tx_valid !== 1'b1 || o_tx_data !== pend_data)
                    $display("FAIL hold_stable: valid=%b data=%02h, need valid=1 data=%02h",
                             o_tx_valid, o_tx_data, pend_data);
                else
                    n_pass++;
            end
            if (o_done === 1'b1) done_cnt++;
            if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1) byte_q.push_back(o_tx_data);
            pend      = (o_tx_valid === 1'b1) && (i_tx_ready !== 1'b1);
            pend_data = o_tx_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = regs[i / 4];
        return w[31 - 8 * (i % 4) -: 8];
    endfunction

    task automatic fill_pattern();
        for (int a = 0; a < 32; a++) regs[a] = 32'(a) * 32'h0101_0101;
    endtask

    task automatic clear_mon();
        byte_q.delete();
        done_cnt = 0;
    endtask

    // Pulse start then run until o_done (or budget); returns edge count
    task automatic run_dump(input bit extra_start, input bit stall,
                            input int limit, output int done_cyc);
        int cyc;
        i_start = 1'b1;
        step();
        i_start  = 1'b0;
        cyc      = 0;
        done_cyc = -1;
        while (cyc < limit && done_cyc < 0) begin
            step();
            cyc++;
            if (o_done === 1'b1) done_cyc = cyc;
            i_start    = extra_start && (cyc == 10 || cyc == 100);
            i_tx_ready = stall ? (cyc % 3 == 0) : 1'b1;
        end
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        step();
        step();
        n_checks++; if (o_rd_addr !== 5'd0) $display("FAIL rst_addr: got %0d need 0", o_rd_addr); else n_pass++;
        n_checks++; if (o_tx_data !== 8'h00) $display("FAIL rst_data: got %02h need 00", o_tx_data); else n_pass++;
        n_checks++; if (o_tx_valid !== 1'b0) $display("FAIL rst_valid: got %b need 0", o_tx_valid); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b need 0", o_busy); else n_pass++;
        n_checks++; if (o_done !== 1'b0) $display("FAIL rst_done: got %b need 0", o_done); else n_pass++;
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_dump();
        int dc;
        int bad;
        fill_pattern();
        clear_mon();
        run_dump(1'b0, 1'b0, 400, dc);
        n_checks++; if (dc !== c_done_cyc) $display("FAIL full_done_cycle: got %0d need %0d", dc, c_done_cyc); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL full_done_count: got %0d need 1", done_cnt); else n_pass++;
        n_checks++; if (byte_q.size() !== c_nbytes) $display("FAIL full_byte_count: got %0d need %0d", byte_q.size(), c_nbytes); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL full_busy_after: got %b need 0", o_busy); else n_pass++;
        if (byte_q.size() >= 128) begin
            n_checks++;
            if ({byte_q[4], byte_q[5], byte_q[6], byte_q[7]} !== 32'h0101_0101)
                $display("FAIL reg1_bytes: got %02h%02h%02h%02h need 01010101", byte_q[4], byte_q[5], byte_q[6], byte_q[7]);
            else n_pass++;
            n_checks++;
            if ({byte_q[124], byte_q[125], byte_q[126], byte_q[127]} !== 32'h1F1F_1F1F)
                $display("FAIL reg31_bytes: got %02h%02h%02h%02h need 1F1F1F1F", byte_q[124], byte_q[125], byte_q[126], byte_q[127]);
            else n_pass++;
            bad = 0;
            for (int i = 0; i < 128; i++) if (byte_q[i] !== exp_byte(i)) bad++;
            n_checks++; if (bad != 0) $display("FAIL byte_stream: got %0d wrong bytes need 0", bad); else n_pass++;
`ifdef REG_DUMP_CHECKSUM_EN
            n_checks++; if (byte_q[128] !== 8'h00) $display("FAIL full_csum: got %02h need 00", byte_q[128]); else n_pass++;
`endif
        end
    endtask

    task automatic test_stall();
        int dc;
        fill_pattern();
        regs[5] = 32'hDEAD_BEEF;
        clear_mon();
        run_dump(1'b0, 1'b1, 2000, dc);
        n_checks++; if (dc < 0) $display("FAIL stall_done: got timeout need done"); else n_pass++;
        n_checks++; if (byte_q.size() !== c_nbytes) $display("FAIL stall_byte_count: got %0d need %0d", byte_q.size(), c_nbytes); else n_pass++;
        if (byte_q.size() >= 24) begin
            n_checks++;
            if ({byte_q[20], byte_q[21], byte_q[22], byte_q[23]} !== 32'hDEAD_BEEF)
                $display("FAIL stall_reg5: got %02h%02h%02h%02h need DEADBEEF", byte_q[20], byte_q[21], byte_q[22], byte_q[23]);
            else n_pass++;
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL stall_done_count: got %0d need 1", done_cnt); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int dc;
        fill_pattern();
        clear_mon();
        run_dump(1'b1, 1'b0, 400, dc);
        n_checks++; if (dc !== c_done_cyc) $display("FAIL restart_done_cycle: got %0d need %0d", dc, c_done_cyc); else n_pass++;
        n_checks++; if (byte_q.size() !== c_nbytes) $display("FAIL restart_byte_count: got %0d need %0d", byte_q.size(), c_nbytes); else n_pass++;
        repeat (20) step();
        n_checks++; if (done_cnt !== 1) $display("FAIL restart_done_count: got %0d need 1", done_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int dc;
        fill_pattern();
        clear_mon();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        cyc = 0;
        while (cyc < 300 && !(o_rd_addr === 5'd7 && o_tx_valid === 1'b1)) begin
            step();
            cyc++;
        end
        n_checks++; if (cyc >= 300) $display("FAIL mid_reach_reg7: got timeout need SEND on reg 7"); else n_pass++;
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_tx_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b need 0", o_tx_valid); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b need 0", o_busy); else n_pass++;
        n_checks++; if (o_rd_addr !== 5'd0) $display("FAIL mid_rst_addr: got %0d need 0", o_rd_addr); else n_pass++;
        step();
        i_rst_n = 1'b1;
        step();
        n_checks++; if (o_busy !== 1'b0) $display("FAIL mid_no_resume: got busy=%b need 0", o_busy); else n_pass++;
        clear_mon();
        run_dump(1'b0, 1'b0, 400, dc);
        n_checks++; if (dc !== c_done_cyc) $display("FAIL mid_redo_cycle: got %0d need %0d", dc, c_done_cyc); else n_pass++;
        if (byte_q.size() >= 8) begin
            n_checks++;
            if ({byte_q[0], byte_q[1], byte_q[2], byte_q[3], byte_q[4], byte_q[5], byte_q[6], byte_q[7]} !== 64'h0000_0000_0101_0101)
                $display("FAIL mid_redo_first: got %02h%02h%02h%02h%02h%02h%02h%02h need 0000000001010101",
                         byte_q[0], byte_q[1], byte_q[2], byte_q[3], byte_q[4], byte_q[5], byte_q[6], byte_q[7]);
            else n_pass++;
        end else begin
            n_checks++;
            $display("FAIL mid_redo_first: got %0d bytes need at least 8", byte_q.size());
        end
    endtask

    task automatic test_no_ready();
        fill_pattern();
        regs[0] = 32'h1234_5678;
        clear_mon();
        i_tx_ready = 1'b0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (300) step();
        n_checks++; if (o_tx_valid !== 1'b1) $display("FAIL noready_valid: got %b need 1", o_tx_valid); else n_pass++;
        n_checks++; if (o_tx_data !== 8'h12) $display("FAIL noready_data: got %02h need 12", o_tx_data); else n_pass++;
        n_checks++; if (o_rd_addr !== 5'd0) $display("FAIL noready_addr: got %0d need 0", o_rd_addr); else n_pass++;
        n_checks++; if (done_cnt !== 0) $display("FAIL noready_done: got %0d need 0", done_cnt); else n_pass++;
        n_checks++; if (o_busy !== 1'b1) $display("FAIL noready_busy: got %b need 1", o_busy); else n_pass++;
        i_rst_n = 1'b0;
        step();
        i_tx_ready = 1'b1;
        i_rst_n = 1'b1;
        step();
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int dc;
        for (int a = 0; a < 32; a++) regs[a] = 32'hA5A5_A5A5;
        regs[0] = 32'h0;
        clear_mon();
        run_dump(1'b0, 1'b0, 400, dc);
        n_checks++; if (byte_q.size() !== 129) $display("FAIL csum_count_a: got %0d need 129", byte_q.size()); else n_pass++;
        if (byte_q.size() >= 129) begin
            n_checks++; if (byte_q[128] !== 8'h00) $display("FAIL csum_a: got %02h need 00", byte_q[128]); else n_pass++;
        end
        regs[1] = 32'h0000_00FF;
        clear_mon();
        run_dump(1'b0, 1'b0, 400, dc);
        n_checks++; if (dc !== 193) $display("FAIL csum_done_cycle: got %0d need 193", dc); else n_pass++;
        if (byte_q.size() >= 129) begin
            n_checks++; if (byte_q[128] !== 8'hFF) $display("FAIL csum_b: got %02h need FF", byte_q[128]); else n_pass++;
        end else begin
            n_checks++;
            $display("FAIL csum_count_b: got %0d need 129", byte_q.size());
        end
    endtask
`endif

    initial begin
        fill_pattern();
        test_reset();
        test_full_dump();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_no_ready();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
